alu_share_ctrl: RTL
===================

# alu_share_ctrl

Sequencer and arbiter that shares the single ALU between two requesters. Requester 0 is the main datapath and requester 1 is an auxiliary unit, such as an address or compare engine. The block grants one request at a time, drives the ALU operands and 3-bit ALU control, captures the result and zero flag, and returns them with a one-cycle done pulse. It sits between the requesters and the combinational ALU. It uses the ALU's existing 3-bit control encoding.

## Interface
- WIDTH, 32, operand/result width

- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req0 / req1  in  1  request; held high with operands stable until matching done
- op0 / op1  in  3  ALU control: 010 add, 110 sub, 000 and, 001 or, 011 xor, 111 slt; 100/101 illegal
- a0, b0 / a1, b1  in  WIDTH  operands
- done0 / done1  out  1  one-cycle completion pulse to the granted requester
- result  out  WIDTH  captured ALU result, shared by both requesters
- zero  out  1  captured ALU zero flag
- err  out  1  high with done when the op was illegal
- busy  out  1  high in EXEC and DONE
- alu_a, alu_b  out  WIDTH  ALU operand drive
- alu_gout  out  3  ALU control drive
- alu_result  in  WIDTH  combinational ALU result
- alu_zero  in  1  combinational ALU zero flag

## Operation
- States: IDLE, EXEC, DONE.
- **IDLE**
  - Sample req0/req1 at the clock edge.
  - If any request is present, register gnt (0/1) and go to EXEC.
  - Otherwise stay in IDLE.
- **Arbitration**
  - One request present: that requester wins.
  - Both present: the round-robin pointer rr wins.
  - rr moves to the other requester after every grant.
  - rr resets to 0.
- **EXEC**
  - alu_a/alu_b/alu_gout = the granted requester's a/b/op, muxed combinationally.
  - At the end of the cycle, capture alu_result into result and alu_zero into zero. Go to DONE.
- **Illegal op (100/101)**
  - Not driven to the ALU: alu_gout = 010, alu_a = alu_b = 0.
  - Captures result = 0, zero = 0, err = 1.
- **DONE**
  - done[gnt] = 1 for exactly one cycle; err is valid in the same cycle.
  - Go to IDLE.
- **Output hold**
  - result/zero hold until the next capture.
  - err clears at the next EXEC.
- **Outside EXEC:** alu_a = alu_b = 0, alu_gout = 010.
- **Requester rule**
  - Drop req in the cycle after done unless issuing a new op.
  - req high in that IDLE cycle is taken as a new back-to-back request.
- **Unsampled requests**
  - req changes during EXEC/DONE are not sampled.
  - A non-granted request stays pending and is served next, via rr.
- **Arithmetic:** none in this block. Results are passed through unmodified at WIDTH bits.

## Timing
- **Latency**
  - req sampled at edge t (IDLE → EXEC).
  - EXEC spans t..t+1; result is registered at t+1.
  - done is high in the cycle t+1..t+2.
- **Throughput:** 3 cycles per op; the minimum spacing between done pulses is 3 cycles.
- **Reset values (asynchronous, while reset_n = 0)**
  - state = IDLE, rr = 0, gnt = 0.
  - done0 = done1 = 0, result = 0, zero = 0, err = 0, busy = 0.
  - alu_a = alu_b = 0, alu_gout = 010.
- **Reset mid-operation**
  - The in-flight op is discarded and no done is issued.
  - After release, the first edge with reset_n = 1 samples requests from IDLE.
- **Combinational paths:** the ALU path alu_* → captured regs is the only combinational path through the block. It lies within EXEC and is single-cycle.

## Configuration
- **ALU_SHARE_FIXED_PRIO_EN**
  - Defined: fixed priority; req0 always wins when both are present; rr is not implemented.
  - Undefined (default): round-robin as described above.

## Test plan
- **Single op:** reset, then req0 = 1, op0 = 010, a0 = 5, b0 = 7.
  - done0 pulses once, 2 cycles after the sampling edge.
  - result = 12, zero = 0, err = 0.
- **Zero flag:** req1 with op1 = 110, a1 = b1 = 0x1234.
  - done1 pulses, result = 0, zero = 1; done0 stays 0.
- **Contention:** req0 and req1 both held continuously.
  - Round-robin: grants alternate 0,1,0,1, with done pulses 3 cycles apart.
  - With ALU_SHARE_FIXED_PRIO_EN: only done0 pulses while req0 stays high.
- **Illegal op:** req0 with op0 = 101.
  - alu_gout stays 010 and alu_a stays 0 during EXEC.
  - done0 with err = 1, result = 0; the next legal op clears err.
- **Reset mid-op:** assert reset_n = 0 during EXEC.
  - All outputs go to reset values immediately; no done follows.
  - After release, a held req1 completes normally.
- **Back-to-back:** requester keeps req0 high with new operands (op0 = 011, a0 = 0xF0, b0 = 0xFF) in the cycle after done.
  - A second done0 arrives 3 cycles after the first, with result = 0x0F.

Source files
------------

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two held requesters; done pulses 2 cycles after sampling, 3 cycles/op, requests wait while busy.
// Define ALU_SHARE_FIXED_PRIO_EN for fixed req0 priority instead of round-robin arbitration.
module alu_share_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [2:0]       op0,
    input  logic [2:0]       op1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             err,
    output logic             busy,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_gout,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero
);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_EXEC = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;
    localparam logic [2:0] OP_ADD = 3'b010;

    logic [1:0]       state;
    logic             gnt;
    logic             win;
    logic             any_req;
    logic [2:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             illegal;
    logic             drive;

    assign any_req = req0 | req1;

`ifdef ALU_SHARE_FIXED_PRIO_EN
    assign win = ~req0;
`else
    logic rr;

    always_comb begin
        win = req1;
        if (req0 && req1) begin
            win = rr;
        end
    end

    // Pointer flips to the loser so a held competitor is served next.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr <= 1'b0;
        end else if (state == S_IDLE && any_req) begin
            rr <= ~win;
        end
    end
`endif

    assign sel_op  = gnt ? op1 : op0;
    assign sel_a   = gnt ? a1 : a0;
    assign sel_b   = gnt ? b1 : b0;
    assign illegal = (sel_op[2:1] == 2'b10);
    assign drive   = (state == S_EXEC) && !illegal;

    assign alu_gout = drive ? sel_op : OP_ADD;
    assign alu_a    = drive ? sel_a : '0;
    assign alu_b    = drive ? sel_b : '0;

    assign done0 = (state == S_DONE) && !gnt;
    assign done1 = (state == S_DONE) && gnt;
    assign busy  = (state != S_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            gnt    <= 1'b0;
            result <= '0;
            zero   <= 1'b0;
            err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        gnt   <= win;
                        err   <= 1'b0;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    result <= illegal ? '0 : alu_result;
                    zero   <= illegal ? 1'b0 : alu_zero;
                    err    <= illegal;
                    state  <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
